// File: rtl/mux_rr_sched_pkg.sv
// Shared types for the round-robin 4:1 mux scheduler: channel count,
// channel index type and the output-register state encoding.
package mux_rr_pkg;

    localparam int CH_NUM = 4;

    typedef logic [1:0] ch_idx_t;

    // Output register occupancy; the encoding doubles as o_valid.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/mux_rr_sched_pick.sv
// Combinational rotate-priority picker: searches last+1, last+2, last+3, last
// and reports the first requesting channel.
module mux_rr_pick
    import mux_rr_pkg::*;
(
    input  logic [CH_NUM-1:0] req,
    input  ch_idx_t           last,
    output logic              found,
    output ch_idx_t           win
);

    // First set request in rotated order wins; offset CH_NUM wraps back onto last.
    always_comb begin
        found = 1'b0;
        win   = last;
        for (int s = 1; s <= CH_NUM; s++) begin
            if (!found && req[ch_idx_t'(last + ch_idx_t'(s))]) begin
                found = 1'b1;
                win   = ch_idx_t'(last + ch_idx_t'(s));
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler and registered output stage for the 4:1 mux datapath,
// handing the selected word downstream over a valid/ready handshake.
module mux_rr_sched
    import mux_rr_pkg::*;
#(
    parameter int width  = 4,
    parameter int swidth = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [width-1:0]  i0,
    input  logic [width-1:0]  i1,
    input  logic [width-1:0]  i2,
    input  logic [width-1:0]  i3,
    output logic [3:0]        ack,
    output logic [swidth-1:0] sel,
    output logic [width-1:0]  o,
    output logic              o_valid,
    input  logic              o_ready
);

    state_e           state_q, state_d;
    ch_idx_t          last_q, last_d;
    ch_idx_t          sel_q, sel_d;
    logic [width-1:0] o_q, o_d;
    logic             load_en_s;
    logic             found_s;
    ch_idx_t          win_s;
    logic [width-1:0] data_sel_s;
    logic [3:0]       ack_s;

    mux_rr_pick u_pick (
        .req   (req),
        .last  (last_q),
        .found (found_s),
        .win   (win_s)
    );

    assign load_en_s = (state_q == EMPTY) || o_ready;

    // Data select for the winning channel.
    always_comb begin
        case (win_s)
            2'd0:    data_sel_s = i0;
            2'd1:    data_sel_s = i1;
            2'd2:    data_sel_s = i2;
            2'd3:    data_sel_s = i3;
            default: data_sel_s = i0;
        endcase
    end

    // Next-state and output-register update; ack is suppressed while in reset.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        o_d     = o_q;
        ack_s   = 4'b0000;
        if (load_en_s) begin
            if (found_s) begin
                state_d = FULL;
                last_d  = win_s;
                sel_d   = win_s;
                o_d     = data_sel_s;
                ack_s   = rst_n ? (4'b0001 << win_s) : 4'b0000;
            end else begin
                state_d = EMPTY;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; pointer resets to 3 so channel 0 leads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            last_q  <= 2'd3;
            sel_q   <= 2'd0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            o_q     <= o_d;
        end
    end

    assign ack     = ack_s;
    assign sel     = sel_q;
    assign o       = o_q;
    assign o_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux_rr_sched.sv
// Randomised scoreboard bench for mux_rr_sched: a queue-based reference model
// predicts grants, a separate monitor checks words as they leave the block.
module tb_mux_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din [4];
    logic [3:0] ack;
    logic [1:0] sel;
    logic [3:0] o;
    logic       o_valid;
    logic       o_ready;

    int checks   = 0;
    int failures = 0;

    logic [5:0] exp_q [$];
    logic       m_valid;
    int         m_last;

    always #5 clk = ~clk;

    mux_rr_sched #(.width(4), .swidth(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .i0      (din[0]),
        .i1      (din[1]),
        .i2      (din[2]),
        .i3      (din[3]),
        .ack     (ack),
        .sel     (sel),
        .o       (o),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: at mid-cycle, predict ack and occupancy, then queue the word to be loaded.
    always @(negedge clk) begin
        int  w;
        bit  found;
        bit  load;
        logic [3:0] exp_ack;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_last  = 3;
            exp_q.delete();
            chk("rst_ack", ack, 32'd0);
            chk("rst_valid", o_valid, 32'd0);
        end else begin
            chk("o_valid", o_valid, m_valid);
            found = 1'b0;
            w     = 0;
            for (int s = 1; s <= 4; s++) begin
                if (!found && req[(m_last + s) % 4]) begin
                    found = 1'b1;
                    w     = (m_last + s) % 4;
                end
            end
            load    = !m_valid || o_ready;
            exp_ack = (load && found) ? (4'b0001 << w) : 4'b0000;
            chk("ack", ack, exp_ack);
            if (load) begin
                if (found) begin
                    exp_q.push_back({w[1:0], din[w]});
                    m_last  = w;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: compare the presented word against the oldest expected entry.
    always @(negedge clk) begin
        #1;
        if (rst_n && o_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=o:%0h sel:%0d required=none", o, sel);
            end else begin
                chk("o", o, exp_q[0][3:0]);
                chk("sel", sel, exp_q[0][5:4]);
                if (o_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic [3:0] r, input logic rdy, input int n);
        req     = r;
        o_ready = rdy;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 4'b0000;
        o_ready = 1'b0;
        din[0]  = 4'hA;
        din[1]  = 4'hB;
        din[2]  = 4'hC;
        din[3]  = 4'hD;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_o", o, 32'd0);
        chk("reset_sel", sel, 32'd0);
        chk("reset_valid", o_valid, 32'd0);
        rst_n = 1'b1;

        cyc(4'b1111, 1'b1, 5);   // rotation 0,1,2,3,0
        cyc(4'b0101, 1'b1, 4);   // sparse 0/2
        cyc(4'b1111, 1'b1, 1);
        cyc(4'b1111, 1'b0, 3);   // backpressure hold
        cyc(4'b1111, 1'b1, 1);
        cyc(4'b0000, 1'b1, 2);   // drain to empty
        cyc(4'b1000, 1'b1, 1);   // restart on ch3
        cyc(4'b1001, 1'b1, 3);   // wrap 3 -> 0
        cyc(4'b1111, 1'b1, 1);
        cyc(4'b1111, 1'b0, 1);

        // Reset while holding a word.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_o", o, 32'd0);
        chk("midrst_sel", sel, 32'd0);
        chk("midrst_valid", o_valid, 32'd0);
        chk("midrst_ack", ack, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'b1111, 1'b1, 2);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 4; c++) din[c] = 4'($urandom_range(0, 15));
            cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1);
        end

        cyc(4'b0000, 1'b1, 4);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_rr_sched.md
Name: mux_rr_sched

Overview:
- Round-robin scheduler and output stage for the parameterised 4:1 mux datapath.
- Four requesters each present a data word and a request.
- The block picks one channel per cycle in fair rotating order, registers the selected word with its channel index (sel), and hands it downstream over a valid/ready handshake.
- Each source gets a one-cycle ack when its word is taken.

Parameters:
width, 4, data word width of i0..i3 and o
swidth, 2, select/channel-index width (fixed at 2 for 4 channels)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  per-channel request; req[k] means ik holds a valid word
i0  input  width  channel 0 data
i1  input  width  channel 1 data
i2  input  width  channel 2 data
i3  input  width  channel 3 data
ack  output  4  one-hot, one-cycle pulse: channel's word captured this cycle
sel  output  swidth  channel index of the word currently held in o
o  output  width  registered selected data
o_valid  output  1  o/sel hold a word for downstream
o_ready  input  1  downstream accepts o when o_valid && o_ready

Behaviour:
- One clock domain (clk); reset is asynchronous, active-low (rst_n).
- Reset values, applied immediately on rst_n low:
  - o=0, sel=0, o_valid=0, ack=4'b0000.
  - Internal last-grant pointer = 3, so channel 0 has first priority after reset.
- load_en = !o_valid || o_ready (output register empty or draining this cycle).
- Arbitration, combinational, in sub-module:
  - Search order is last+1, last+2, last+3, last (mod 4).
  - The first k with req[k]=1 wins.
  - No req set means no winner.
- On a clk edge with load_en=1 and a winner k:
  - o <= ik, sel <= k, o_valid <= 1, last <= k.
  - ack is exactly 4'b1 << k for that cycle.
- On a clk edge with load_en=1 and no winner: o_valid <= 0; o and sel keep their last values; ack=0.
- On a clk edge with load_en=0 (stall): o, sel, o_valid and last are unchanged; ack=0.
- ack is combinational from load_en and the winner; sources may drop or replace data on the next edge.
- State machine (2 states, encoded by o_valid):
  - EMPTY -> FULL: a winner exists.
  - FULL -> FULL: o_ready && winner (back-to-back transfer, full throughput of 1 word/cycle).
  - FULL -> FULL: !o_ready (hold).
  - FULL -> EMPTY: o_ready && no winner.
- Latency: req/data sampled at edge N; o_valid/o/sel visible after edge N; ack asserted in cycle N-1..N (the same cycle the sample is taken).
- Boundaries:
  - Pointer wraps 3 -> 0.
  - A single persistent requester is granted every cycle.
  - A req dropped while stalled is simply not granted.
  - o and sel are stable for the whole stall.
  - rst_n asserted mid-hold discards the held word with no ack, and the pointer returns to 3.
  - Asynchronous reset release is synchronised by the system; the block does not resynchronise it.

Decomposition:
- Package mux_rr_pkg:
  - CH_NUM=4.
  - Channel index type (logic [1:0]).
  - State enum {EMPTY, FULL} for readability of o_valid.
- Sub-module mux_rr_pick:
  - Purely combinational rotate-priority picker.
  - Inputs: req[3:0], last[1:0].
  - Outputs: found, win[1:0].
- Top instantiates mux_rr_pick plus the case-based data select and output register.

Test Plan:
All scenarios use i0=4'hA, i1=4'hB, i2=4'hC, i3=4'hD unless stated.
1. Round-robin rotation: after reset, req=4'b1111, o_ready=1 -> five consecutive edges give sel=0,1,2,3,0; o=A,B,C,D,A; ack=0001,0010,0100,1000,0001.
2. Sparse requests: req=4'b0101, o_ready=1 -> sel alternates 0,2,0,2; o=A,C,A,C; ack never 0010/1000.
3. Backpressure: req=4'b1111; after the first grant (o=A, sel=0) hold o_ready=0 for 3 cycles -> o=A, sel=0, o_valid=1, ack=0000 throughout; raise o_ready -> next edge o=B, sel=1.
4. Drain to empty and restart: req=4'b0000 with o_valid=1, o_ready=1 -> o_valid=0 after one edge, ack=0; then req=4'b1000 -> next edge o=D, sel=3, o_valid=1.
5. Wrap: last=3 via a prior ch3 grant, req=4'b1001, o_ready=1 -> grants ch0 then ch3 then ch0.
6. Reset mid-operation: o_valid=1, o_ready=0, pull rst_n low between edges -> o_valid=0, o=0, sel=0 immediately, ack=0; release with req=4'b1111 -> first grant sel=0, o=A.
